// File: rtl/reg_status_file_pkg.sv
// ----------------------------------------------------------------------------
// reg_status_file_pkg
// Shared constants for the architectural register/status file and its read
// bypass. The zero constants and the boolean encodings are the same ones used
// elsewhere in the core, so both sides of an interface read alike.
// ----------------------------------------------------------------------------
package reg_status_file_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int ROB_W_DEFAULT = 4;
    localparam int NREG_DEFAULT  = 32;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [XLEN_DEFAULT-1:0]          ZERO_DATA = '0;
    localparam logic [ROB_W_DEFAULT-1:0]         ZERO_ROB  = '0;
    localparam logic [$clog2(NREG_DEFAULT)-1:0]  ZERO_REG  = '0;

endpackage : reg_status_file_pkg

// File: rtl/reg_read_bypass.sv
// ----------------------------------------------------------------------------
// reg_read_bypass
// One decoder read port. Takes the stored {busy, tag, data} of the addressed
// register and overlays the youngest same-cycle commit to that register, so an
// operand that retires in the lookup cycle is seen without a bubble.
//
// Ports:
//   addr          register being read
//   st_busy/tag/data  stored entry for addr (pre-update state)
//   commit_*      all commit ports, packed, port 0 oldest
//   busy/tag/data resolved operand status
// There is no handshake on this path: it is purely combinational.
// ----------------------------------------------------------------------------
module reg_read_bypass
    import reg_status_file_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREG  = NREG_DEFAULT,
    parameter int ROB_W = ROB_W_DEFAULT,
    parameter int NCP   = 2,
    localparam int RW   = $clog2(NREG)
) (
    input  logic [RW-1:0]        addr,
    input  logic                 st_busy,
    input  logic [ROB_W-1:0]     st_tag,
    input  logic [XLEN-1:0]      st_data,
    input  logic [NCP-1:0]       commit_enable,
    input  logic [NCP*RW-1:0]    commit_rd,
    input  logic [NCP*XLEN-1:0]  commit_value,
    input  logic [NCP*ROB_W-1:0] commit_tag,
    output logic                 busy,
    output logic [ROB_W-1:0]     tag,
    output logic [XLEN-1:0]      data
);

    logic             hit;
    logic [ROB_W-1:0] sel_tag;

    always_comb begin
        busy    = st_busy;
        tag     = st_tag;
        data    = st_data;
        hit     = FALSE;
        sel_tag = '0;
        // Ascending scan: the last match is the youngest commit, which wins.
        for (int c = 0; c < NCP; c++) begin
            if (commit_enable[c] && (commit_rd[c*RW +: RW] == addr)) begin
                hit     = TRUE;
                data    = commit_value[c*XLEN +: XLEN];
                sel_tag = commit_tag[c*ROB_W +: ROB_W];
            end
        end
        // Only the youngest commit's tag decides whether the rename retires;
        // a stale commit refreshes data but leaves the newer rename pending.
        if (hit && st_busy && (st_tag == sel_tag)) begin
            busy = FALSE;
            tag  = '0;
        end
        // x0 is hardwired, including against bypass.
        if (addr == '0) begin
            busy = FALSE;
            tag  = '0;
            data = '0;
        end
    end

endmodule : reg_read_bypass

// File: rtl/reg_status_file.sv
// ----------------------------------------------------------------------------
// reg_status_file
// Architectural register file with per-register busy/reorder-tag status.
// Decoder looks operands up through NRP combinational read ports; the ROB
// retires up to NCP results per cycle in program order (port 0 oldest).
//
// Ports:
//   in_clk, in_rst        clock, asynchronous active-high reset
//   in_rdy                global stall; low freezes all state
//   in_flush_enable       misprediction flush: clear all renames
//   in_dispatch_*         rename one destination to a ROB tag
//   in_read_addr          NRP operand addresses
//   out_read_busy/data/tag  operand status per read port
//   in_commit_*           NCP commit ports
// There is no valid/ready handshake: every enable is sampled on the rising
// edge with in_rdy high, and the ROB guarantees ordering and tag uniqueness.
// ----------------------------------------------------------------------------
module reg_status_file
    import reg_status_file_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREG  = NREG_DEFAULT,
    parameter int ROB_W = ROB_W_DEFAULT,
    parameter int NRP   = 2,
    parameter int NCP   = 2,
    localparam int RW   = $clog2(NREG)
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_rdy,
    input  logic                 in_flush_enable,
    input  logic                 in_dispatch_enable,
    input  logic [RW-1:0]        in_dispatch_rd,
    input  logic [ROB_W-1:0]     in_dispatch_tag,
    input  logic [NRP*RW-1:0]    in_read_addr,
    output logic [NRP-1:0]       out_read_busy,
    output logic [NRP*XLEN-1:0]  out_read_data,
    output logic [NRP*ROB_W-1:0] out_read_tag,
    input  logic [NCP-1:0]       in_commit_enable,
    input  logic [NCP*RW-1:0]    in_commit_rd,
    input  logic [NCP*XLEN-1:0]  in_commit_value,
    input  logic [NCP*ROB_W-1:0] in_commit_tag
);

    logic [XLEN-1:0]  data_q [NREG];
    logic [ROB_W-1:0] tag_q  [NREG];
    logic [NREG-1:0]  busy_q;

    logic [XLEN-1:0]  data_d [NREG];
    logic [ROB_W-1:0] tag_d  [NREG];
    logic [NREG-1:0]  busy_d;

    // Unpacked views of the commit ports.
    logic [RW-1:0]    c_rd    [NCP];
    logic [XLEN-1:0]  c_value [NCP];
    logic [ROB_W-1:0] c_tag   [NCP];

    for (genvar c = 0; c < NCP; c++) begin : g_commit_view
        assign c_rd[c]    = in_commit_rd[c*RW +: RW];
        assign c_value[c] = in_commit_value[c*XLEN +: XLEN];
        assign c_tag[c]   = in_commit_tag[c*ROB_W +: ROB_W];
    end

    // ------------------------------------------------------------------
    // Next-state: commits in port order, then flush or dispatch.
    // ------------------------------------------------------------------
    always_comb begin
        data_d = data_q;
        tag_d  = tag_q;
        busy_d = busy_q;

        for (int c = 0; c < NCP; c++) begin
            if (in_commit_enable[c] && (c_rd[c] != '0)
                && ($unsigned(32'(c_rd[c])) < $unsigned(NREG))) begin
                data_d[c_rd[c]] = c_value[c];
                // Compare against the pre-cycle tag: a commit whose tag has
                // since been superseded by a newer rename must not clear it.
                if (tag_q[c_rd[c]] == c_tag[c]) begin
                    busy_d[c_rd[c]] = FALSE;
                    tag_d[c_rd[c]]  = '0;
                end
            end
        end

        if (in_flush_enable) begin
            // Commits above still land their data; only renames are dropped.
            busy_d = '0;
            for (int r = 0; r < NREG; r++) begin
                tag_d[r] = '0;
            end
        end else if (in_dispatch_enable && (in_dispatch_rd != '0)
                     && ($unsigned(32'(in_dispatch_rd)) < $unsigned(NREG))) begin
            // Applied after commits so a new rename beats a same-cycle retire.
            busy_d[in_dispatch_rd] = TRUE;
            tag_d[in_dispatch_rd]  = in_dispatch_tag;
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            data_q <= '{default: '0};
            tag_q  <= '{default: '0};
            busy_q <= '0;
        end else if (in_rdy) begin
            data_q <= data_d;
            tag_q  <= tag_d;
            busy_q <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NRP; p++) begin : g_read
        logic [RW-1:0]    ra;
        logic             in_range;
        logic             st_busy;
        logic [ROB_W-1:0] st_tag;
        logic [XLEN-1:0]  st_data;

        assign ra       = in_read_addr[p*RW +: RW];
        assign in_range = ($unsigned(32'(ra)) < $unsigned(NREG));
        assign st_busy  = in_range ? busy_q[ra] : FALSE;
        assign st_tag   = in_range ? tag_q[ra]  : '0;
        assign st_data  = in_range ? data_q[ra] : '0;

        reg_read_bypass #(
            .XLEN  (XLEN),
            .NREG  (NREG),
            .ROB_W (ROB_W),
            .NCP   (NCP)
        ) u_bypass (
            .addr          (ra),
            .st_busy       (st_busy),
            .st_tag        (st_tag),
            .st_data       (st_data),
            .commit_enable (in_commit_enable),
            .commit_rd     (in_commit_rd),
            .commit_value  (in_commit_value),
            .commit_tag    (in_commit_tag),
            .busy          (out_read_busy[p]),
            .tag           (out_read_tag[p*ROB_W +: ROB_W]),
            .data          (out_read_data[p*XLEN +: XLEN])
        );
    end

endmodule : reg_status_file
